// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DBG = 1'b1
    } arb_state_t;

    localparam int DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/dmem_arbiter_flopr.sv
// Plain N-bit register with asynchronous active-high reset to zero.
module flopr #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage has priority, debug port is
// guaranteed service after at most MAX_WAIT yielded cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N        = 64,
    parameter int AW       = 6,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [N-1:0]  cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    output logic [N-1:0]  cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [N-1:0]  dbg_wdata,
    output logic          dbg_gnt,
    output logic [N-1:0]  dbg_rdata,
    output logic          dbg_rvalid,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    arb_state_t    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [N-1:0]  dbg_rdata_d;
    logic          cpu_active;
    logic          unused_addr_bits;

    assign cpu_active       = cpu_read | cpu_write;
    assign cpu_rdata        = mem_rdata;
    assign dbg_rvalid       = dbg_rvalid_q;
    assign unused_addr_bits = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};

    always_comb begin
        mem_read  = cpu_read;
        mem_write = cpu_write;
        mem_addr  = cpu_addr[AW+2:3];
        mem_wdata = cpu_wdata;
        dbg_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (state_q == S_DBG) begin
            mem_read  = dbg_req & ~dbg_we;
            mem_write = dbg_req & dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            dbg_gnt   = 1'b1;
            cpu_stall = cpu_active;
        end
    end

    // The wait count can only reach MAX_WAIT while the CPU keeps the port busy,
    // and at that value the debug side is taken next, so it never overflows.
    always_comb begin
        state_d      = S_CPU;
        wait_d       = '0;
        dbg_rvalid_d = 1'b0;
        if (state_q == S_DBG) begin
            dbg_rvalid_d = dbg_req & ~dbg_we;
        end else if (dbg_req) begin
            if (!cpu_active || wait_q == WW'(MAX_WAIT)) state_d = S_DBG;
            else                                        wait_d  = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CPU;
            wait_q       <= '0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    assign dbg_rdata_d = (state_q == S_DBG) ? mem_rdata : dbg_rdata;

    flopr #(.N(N)) u_dbg_rdata (
        .clk   (clk),
        .reset (reset),
        .d     (dbg_rdata_d),
        .q     (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a cycle-level behavioural
// model of the arbitration rules and a shadow copy of memory.
module tb_dmem_arbiter;

    localparam int N        = 64;
    localparam int AW       = 6;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_read, cpu_write;
    logic [N-1:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [N-1:0]  dbg_wdata, dbg_rdata;
    logic          dbg_gnt, dbg_rvalid;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata, mem_rdata;

    dmem_arbiter #(.N(N), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory the arbiter drives: combinational read, clocked write.
    logic [N-1:0] dmem [0:(1<<AW)-1];
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) if (mem_write) dmem[mem_addr] <= mem_wdata;

    // Reference model state.
    logic [N-1:0] ref_mem [0:(1<<AW)-1];
    logic         m_gnt;
    int           m_streak;
    logic         m_rvalid;
    logic [N-1:0] m_rdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt    = 1'b0;
        m_streak = 0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // One clock cycle: check combinational outputs mid-cycle, then advance the
    // model with this cycle's inputs and check the registered outputs.
    task automatic tick();
        logic [AW-1:0] cw;
        logic          cpu_act, nrv;
        cw      = cpu_addr[AW+2:3];
        cpu_act = cpu_read | cpu_write;
        @(negedge clk);
        chk("dbg_gnt", {63'd0, dbg_gnt}, {63'd0, m_gnt});
        chk("cpu_stall", {63'd0, cpu_stall}, {63'd0, m_gnt & cpu_act});
        if (m_gnt) begin
            chk("mem_read_dbg", {63'd0, mem_read}, {63'd0, dbg_req & ~dbg_we});
            chk("mem_write_dbg", {63'd0, mem_write}, {63'd0, dbg_req & dbg_we});
            if (dbg_req) chk("mem_addr_dbg", {58'd0, mem_addr}, {58'd0, dbg_addr});
            if (dbg_req & dbg_we) chk("mem_wdata_dbg", mem_wdata, dbg_wdata);
        end else begin
            chk("mem_read_cpu", {63'd0, mem_read}, {63'd0, cpu_read});
            chk("mem_write_cpu", {63'd0, mem_write}, {63'd0, cpu_write});
            chk("mem_addr_cpu", {58'd0, mem_addr}, {58'd0, cw});
            if (cpu_write) chk("mem_wdata_cpu", mem_wdata, cpu_wdata);
            chk("cpu_rdata", cpu_rdata, ref_mem[cw]);
        end
        @(posedge clk);
        nrv = m_gnt & dbg_req & ~dbg_we;
        if (m_gnt) m_rdata = ref_mem[dbg_addr];
        if (m_gnt && dbg_req && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
        else if (!m_gnt && cpu_write)   ref_mem[cw] = cpu_wdata;
        // A grant is always followed by a CPU cycle; otherwise debug wins when
        // the CPU is idle or has already made it wait MAX_WAIT cycles.
        if (m_gnt) begin
            m_gnt    = 1'b0;
            m_streak = 0;
        end else if (dbg_req) begin
            if (!cpu_act || m_streak >= MAX_WAIT) begin
                m_gnt    = 1'b1;
                m_streak = 0;
            end else begin
                m_streak++;
            end
        end else begin
            m_streak = 0;
        end
        m_rvalid = nrv;
        #1;
        chk("dbg_rvalid", {63'd0, dbg_rvalid}, {63'd0, m_rvalid});
        chk("dbg_rdata", dbg_rdata, m_rdata);
    endtask

    task automatic cpu_idle();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
    endtask

    initial begin
        int          lat;
        logic        last_gnt;
        logic [N-1:0] a;

        for (int i = 0; i < (1 << AW); i++) begin
            dmem[i]    = 64'h1111_0000_0000_0000 * i + 64'(i);
            ref_mem[i] = 64'h1111_0000_0000_0000 * i + 64'(i);
        end
        cpu_idle();
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", {63'd0, dbg_gnt}, 64'd0);
        chk("rst_rvalid", {63'd0, dbg_rvalid}, 64'd0);
        chk("rst_rdata", dbg_rdata, 64'd0);
        chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
        reset = 1'b0;

        // Debug write to 5 with CPU idle, then read it back.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd5; dbg_wdata = 64'hDEAD;
        tick();
        chk("wr_gnt_next", {63'd0, dbg_gnt}, 64'd1);
        chk("wr_mem_write", {63'd0, mem_write}, 64'd1);
        chk("wr_mem_addr", {58'd0, mem_addr}, 64'd5);
        tick();
        dbg_req = 1'b0;
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
        tick();
        tick();
        dbg_req = 1'b0;
        chk("rd_rvalid", {63'd0, dbg_rvalid}, 64'd1);
        chk("rd_rdata", dbg_rdata, 64'hDEAD);
        tick();
        chk("rd_rvalid_pulse", {63'd0, dbg_rvalid}, 64'd0);

        // CPU reading 0x18 every cycle; debug read must wait MAX_WAIT cycles.
        cpu_read = 1'b1; cpu_addr = 64'h18;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd7;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (dbg_gnt !== 1'b1 && lat < 20);
        chk("gnt_latency", 64'(lat), 64'(MAX_WAIT + 1));
        chk("busy_stall", {63'd0, cpu_stall}, 64'd1);
        tick();
        dbg_req = 1'b0;
        chk("busy_stall_one", {63'd0, cpu_stall}, 64'd0);
        tick();

        // CPU store during a debug grant is deferred to the next CPU cycle.
        cpu_idle();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd1;
        tick();
        cpu_write = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'hCAFE_F00D;
        tick();
        dbg_req = 1'b0;
        chk("st_not_written", dmem[2], ref_mem[2]);
        tick();
        chk("st_written", dmem[2], 64'hCAFE_F00D);
        cpu_idle();
        cpu_read = 1'b1; cpu_addr = 64'h10;
        tick();
        cpu_idle();

        // Continuous debug request, CPU idle: grants alternate.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alt_gnt", {63'd0, dbg_gnt}, (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        dbg_req = 1'b0;
        tick();
        tick();

        // Reset asserted inside a debug grant cycle (read, then write).
        for (int k = 0; k < 2; k++) begin
            dbg_req = 1'b1; dbg_we = k[0]; dbg_addr = 6'd9; dbg_wdata = 64'hBAD0;
            tick();
            #2 reset = 1'b1;
            #1;
            chk("rstmid_gnt", {63'd0, dbg_gnt}, 64'd0);
            chk("rstmid_rvalid", {63'd0, dbg_rvalid}, 64'd0);
            dbg_req = 1'b0;
            model_reset();
            #1 reset = 1'b0;
            cpu_read = 1'b1; cpu_addr = 64'h48;
            tick();
            cpu_idle();
        end

        // Request dropped during the grant cycle: no access, no response.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd4;
        tick();
        dbg_req = 1'b0;
        tick();
        chk("drop_rvalid", {63'd0, dbg_rvalid}, 64'd0);
        tick();

        // Random traffic; debug requests are held until granted.
        last_gnt = 1'b0;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0: begin cpu_read = 1'b0; cpu_write = 1'b0; end
                2: begin cpu_read = 1'b0; cpu_write = 1'b1; end
                default: begin cpu_read = 1'b1; cpu_write = 1'b0; end
            endcase
            a = {$urandom, $urandom};
            a[AW+2:3] = AW'($urandom_range(7));
            cpu_addr  = a;
            cpu_wdata = {$urandom, $urandom};
            if (last_gnt || (!dbg_req && !m_gnt && $urandom_range(2) == 0)) begin
                dbg_req   = (last_gnt) ? 1'($urandom_range(1)) : 1'b1;
                dbg_we    = 1'($urandom_range(1));
                dbg_addr  = AW'($urandom_range(7));
                dbg_wdata = {$urandom, $urandom};
            end else if (m_gnt && $urandom_range(7) == 0) begin
                dbg_req = 1'b0;
            end
            last_gnt = m_gnt;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter for the single-port data memory, shared between the pipelined processor's MEM stage and an external debug/load port. The CPU has priority. A bounded wait counter guarantees a pending debug access is served within MAX_WAIT+1 cycles. While debug owns the port, the arbiter drives `cpu_stall` so the pipeline holds its MEM-stage access. The block sits between the datapath's `DM_*` outputs and `dmem`.

## Interface
Parameters:
- `N`, 64: data width.
- `AW`, 6: memory word-address width. The CPU word index is `cpu_addr[AW+2:3]`.
- `MAX_WAIT`, 4: maximum cycles a pending debug request yields to active CPU accesses.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `cpu_read` in 1: MEM-stage read enable (`DM_readEnable`).
- `cpu_write` in 1: MEM-stage write enable (`DM_writeEnable`).
- `cpu_addr` in N: byte address (`DM_addr`).
- `cpu_wdata` in N: store data.
- `cpu_rdata` out N: load data to the datapath.
- `cpu_stall` out 1: CPU access not performed this cycle; the pipeline must hold.
- `dbg_req` in 1: debug request, held until `dbg_gnt`.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in AW: word address.
- `dbg_wdata` in N: debug write data.
- `dbg_gnt` out 1: debug owns the port this cycle.
- `dbg_rdata` out N: registered read data.
- `dbg_rvalid` out 1: `dbg_rdata` valid, single-cycle pulse.
- `mem_read` out 1: to `dmem.memRead`.
- `mem_write` out 1: to `dmem.memWrite`.
- `mem_addr` out AW: to `dmem.address`.
- `mem_wdata` out N: to `dmem.writeData`.
- `mem_rdata` in N: from `dmem.readData`, combinational.

## Operation
- `cpu_active = cpu_read | cpu_write`.
- Two states: S_CPU (reset state) and S_DBG.
- **S_CPU**
  - mem outputs mirror CPU inputs; `cpu_rdata = mem_rdata`.
  - `dbg_gnt = 0`, `cpu_stall = 0`.
  - Transition to S_DBG when `dbg_req & (~cpu_active | wait_cnt == MAX_WAIT)`.
- **S_DBG**
  - mem outputs driven from the debug port.
  - `mem_write = dbg_req & dbg_we`; `mem_read = dbg_req & ~dbg_we`.
  - `dbg_gnt = 1`; `cpu_stall = cpu_active`. A CPU write in this cycle is not issued.
  - Always returns to S_CPU. Back-to-back debug accesses therefore get at least one S_CPU cycle between them (no CPU starvation).
- **wait_cnt** (width `$clog2(MAX_WAIT+1)`)
  - In S_CPU with `dbg_req & cpu_active`: increment, saturating at MAX_WAIT.
  - Cleared on entry to S_DBG or whenever `dbg_req = 0`.
- **Debug read response**
  - Registered on the S_DBG cycle: `dbg_rdata <= mem_rdata` and `dbg_rvalid <= dbg_req & ~dbg_we`.
  - Otherwise `dbg_rvalid <= 0` and `dbg_rdata` holds its value.
- **Debug request dropped during S_DBG:** grant is still shown, no memory access occurs, no `dbg_rvalid`.
- **Reset values:** state S_CPU, `wait_cnt` 0, `dbg_rvalid` 0, `dbg_rdata` 0. Combinational outputs follow S_CPU with CPU inputs.

## Timing
- CPU access in S_CPU: zero added latency, same cycle as the unarbitrated path.
- Debug, CPU idle: `dbg_req` rises at cycle t, `dbg_gnt` at t+1, `dbg_rvalid` at t+2.
- Debug, CPU continuously active: `dbg_gnt` no later than t+MAX_WAIT+1.
- `cpu_stall` is asserted only in S_DBG cycles, at most one consecutive cycle.
- Reset asserted mid-S_DBG: state returns to S_CPU immediately and any in-flight `dbg_rvalid` is cleared. A debug write whose clock edge did not occur is not performed.

## Structure
- Package `dmem_arb_pkg`: `arb_state_t` enum {S_CPU, S_DBG} and the default MAX_WAIT constant.
- The `dbg_rdata` register is a `flopr #(N)` instance, with enable implemented by a hold mux. No other sub-module.

## Test plan
- Reset with CPU idle; `dbg_req=1`, `dbg_we=1`, `dbg_addr=5`, `dbg_wdata=0xDEAD` -> `dbg_gnt` one cycle later with `mem_write=1`, `mem_addr=5`. A subsequent debug read of address 5 -> `dbg_rvalid` pulse with `dbg_rdata=0xDEAD`.
- CPU reads every cycle at `cpu_addr=0x18` with a debug read pending -> `dbg_gnt` exactly MAX_WAIT+1 cycles after `dbg_req`. `cpu_stall=1` only in that cycle; `cpu_rdata=mem[3]` on all other cycles.
- CPU store at `cpu_addr=0x10` issued in an S_DBG cycle -> not written while stalled, written in the next S_CPU cycle once the pipeline re-presents it.
- `dbg_req` held high continuously with the CPU idle -> grants alternate S_DBG/S_CPU and never occur on consecutive cycles.
- Reset asserted in an S_DBG cycle of a debug read -> `dbg_gnt` and `dbg_rvalid` both 0 and state S_CPU before the next edge.
- `dbg_req` dropped in the S_DBG cycle -> `mem_read=0`, `mem_write=0`, no `dbg_rvalid`.
